palette_lut_banked: RTL and testbench

//  Runtime-writable, double-buffered colour palette for sprite/background pixels.

---
 rtl/palette_lut_banked.sv | 144 ++++++++++++++
 tb/tb_palette_lut_banked.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/palette_lut_banked.sv
// Double-buffered colour palette: 2-cycle pipelined index -> {r,g,b} lookup with a
// shadow bank swapped only at frame_start. Optional PALETTE_DIM_EN adds per-frame dimming.
module palette_lut_banked #(
    parameter int INDEX_W    = 4,
    parameter int COLOR_W    = 4,
    parameter int TRANSP_IDX = 0
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   pix_valid_in,
    input  logic [INDEX_W-1:0]     index,
    output logic                   pix_valid_out,
    output logic [COLOR_W-1:0]     red,
    output logic [COLOR_W-1:0]     green,
    output logic [COLOR_W-1:0]     blue,
    output logic                   transparent,
    input  logic                   wr_en,
    input  logic [INDEX_W-1:0]     wr_addr,
    input  logic [3*COLOR_W-1:0]   wr_data,
    input  logic                   swap_req,
    input  logic                   frame_start,
`ifdef PALETTE_DIM_EN
    input  logic [1:0]             dim_level,
`endif
    output logic                   swap_pending,
    output logic                   active_bank
);

    localparam int DEPTH = 1 << INDEX_W;
    localparam int ENTRY_W = 3 * COLOR_W;

    logic [ENTRY_W-1:0] r_mem [2][DEPTH];
    logic               r_active_bank;
    logic               r_swap_pending;
    logic               r_s1_valid;
    logic [INDEX_W-1:0] r_s1_index;
    logic               r_valid_out;
    logic [COLOR_W-1:0] r_red;
    logic [COLOR_W-1:0] r_green;
    logic [COLOR_W-1:0] r_blue;
    logic               r_transparent;

    logic               w_wr_bank;
    logic [ENTRY_W-1:0] w_entry;
    logic [1:0]         w_shift;
    logic [COLOR_W-1:0] w_red;
    logic [COLOR_W-1:0] w_green;
    logic [COLOR_W-1:0] w_blue;

    // Writes always go to whichever bank is not currently being displayed.
    assign w_wr_bank = ~r_active_bank;

    // NOTE: the palette is a flop array, so it can be reset like any register;
    // a RAM macro could not be cleared this way.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int e = 0; e < DEPTH; e++) begin
                    r_mem[b][e] <= '0;
                end
            end
        end else if (wr_en) begin
            r_mem[w_wr_bank][wr_addr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_active_bank  <= 1'b0;
            r_swap_pending <= 1'b0;
        end else if (frame_start) begin
            if (r_swap_pending || swap_req) begin
                r_active_bank  <= ~r_active_bank;
                r_swap_pending <= 1'b0;
            end
        end else if (swap_req) begin
            r_swap_pending <= 1'b1;
        end
    end

`ifdef PALETTE_DIM_EN
    logic [1:0] r_dim_level;

    // Dimming is frame-synchronous, exactly like the bank swap.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_dim_level <= 2'd0;
        end else if (frame_start) begin
            r_dim_level <= dim_level;
        end
    end

    assign w_shift = r_dim_level;
`else
    assign w_shift = 2'd0;
`endif

    // Stage-2 read uses the bank active in that very cycle, so a swap is seen
    // by the read in the cycle after frame_start.
    assign w_entry = r_mem[r_active_bank][r_s1_index];
    assign w_red   = w_entry[3*COLOR_W-1:2*COLOR_W] >> w_shift;
    assign w_green = w_entry[2*COLOR_W-1:COLOR_W]   >> w_shift;
    assign w_blue  = w_entry[COLOR_W-1:0]           >> w_shift;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_index <= '0;
        end else begin
            r_s1_valid <= pix_valid_in;
            r_s1_index <= index;
        end
    end

    // Colour outputs only update on valid pixels and hold otherwise.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_valid_out   <= 1'b0;
            r_red         <= '0;
            r_green       <= '0;
            r_blue        <= '0;
            r_transparent <= 1'b0;
        end else begin
            r_valid_out <= r_s1_valid;
            if (r_s1_valid) begin
                r_red         <= w_red;
                r_green       <= w_green;
                r_blue        <= w_blue;
                r_transparent <= (r_s1_index == INDEX_W'(TRANSP_IDX));
            end
        end
    end

    assign pix_valid_out = r_valid_out;
    assign red           = r_red;
    assign green         = r_green;
    assign blue          = r_blue;
    assign transparent   = r_transparent;
    assign swap_pending  = r_swap_pending;
    assign active_bank   = r_active_bank;

endmodule

// File: tb/tb_palette_lut_banked.sv
// Scoreboard bench for palette_lut_banked: a frame-level palette model predicts each
// pixel, a negedge monitor compares whenever pix_valid_out is high.
module tb_palette_lut_banked;

    localparam int IW   = 4;
    localparam int CW   = 4;
    localparam int TIDX = 0;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          pix_valid_in = 1'b0;
    logic [IW-1:0] index = '0;
    logic          pix_valid_out;
    logic [CW-1:0] red, green, blue;
    logic          transparent;
    logic          wr_en = 1'b0;
    logic [IW-1:0] wr_addr = '0;
    logic [3*CW-1:0] wr_data = '0;
    logic          swap_req = 1'b0;
    logic          frame_start = 1'b0;
    logic [1:0]    dim_level = 2'd0;
    logic          swap_pending;
    logic          active_bank;

    palette_lut_banked #(.INDEX_W(IW), .COLOR_W(CW), .TRANSP_IDX(TIDX)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .pix_valid_in(pix_valid_in), .index(index),
        .pix_valid_out(pix_valid_out), .red(red), .green(green), .blue(blue),
        .transparent(transparent),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .swap_req(swap_req), .frame_start(frame_start),
`ifdef PALETTE_DIM_EN
        .dim_level(dim_level),
`endif
        .swap_pending(swap_pending), .active_bank(active_bank)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int unsigned cyc;
        logic [3*CW-1:0] rgb;
        logic            t;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: two palettes, which one is shown, and a pending-swap flag.
    logic [3*CW-1:0] pal [2][1<<IW];
    int          m_active = 0;
    bit          m_pend = 0;
    int          m_dim = 0;
    bit          s1_have = 0;
    int          s1_idx = 0;
    int unsigned cyc = 0;

    always @(posedge Clk) begin
        cyc++;
        if (!Reset_n) begin
            for (int b = 0; b < 2; b++)
                for (int e = 0; e < (1 << IW); e++) pal[b][e] = '0;
            m_active = 0;
            m_pend   = 0;
            m_dim    = 0;
            s1_have  = 0;
            exp_q.delete();
        end else begin
            if (s1_have) begin
                exp_t x;
                logic [3*CW-1:0] e;
                e = pal[m_active][s1_idx];
                x.cyc = cyc;
                x.rgb = {e[3*CW-1:2*CW] >> m_dim, e[2*CW-1:CW] >> m_dim, e[CW-1:0] >> m_dim};
                x.t   = (s1_idx == TIDX);
                exp_q.push_back(x);
            end
            if (wr_en) pal[1 - m_active][wr_addr] = wr_data;
            if (frame_start) begin
                if (m_pend || swap_req) begin
                    m_active = 1 - m_active;
                    m_pend   = 0;
                end
`ifdef PALETTE_DIM_EN
                m_dim = dim_level;
`endif
            end else if (swap_req) begin
                m_pend = 1;
            end
            s1_have = pix_valid_in;
            s1_idx  = index;
        end
    end

    // Monitor: compares bank state every cycle and pixels whenever valid.
    logic [3*CW:0] last_out = '0;

    always @(negedge Clk) begin
        if (!Reset_n) begin
            last_out = '0;
            check("reset_valid", 32'(pix_valid_out), 0);
            check("reset_rgbt", 32'({red, green, blue, transparent}), 0);
            check("reset_bank", 32'({active_bank, swap_pending}), 0);
        end else begin
            check("active_bank", 32'(active_bank), 32'(m_active));
            check("swap_pending", 32'(swap_pending), 32'(m_pend));
            if (pix_valid_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", 32'(pix_valid_out), 0);
                end else begin
                    exp_t x;
                    x = exp_q.pop_front();
                    check("latency_cycle", cyc, x.cyc);
                    check("rgb", 32'({red, green, blue}), 32'(x.rgb));
                    check("transparent", 32'(transparent), 32'(x.t));
                    last_out = {x.rgb, x.t};
                end
            end else begin
                check("hold", 32'({red, green, blue, transparent}), 32'(last_out));
            end
        end
    end

    task automatic drive(input bit pv, input int idx, input bit we, input int wa,
                         input logic [3*CW-1:0] wd, input bit sr, input bit fs);
        pix_valid_in = pv;
        index        = IW'(idx);
        wr_en        = we;
        wr_addr      = IW'(wa);
        wr_data      = wd;
        swap_req     = sr;
        frame_start  = fs;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, '0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge Clk);
        #1 Reset_n = 1'b1;
        idle(1);

        // Cleared palette returns black for a non-transparent index.
        drive(1, 5, 0, 0, '0, 0, 0);
        idle(3);

        // Shadow write then swap; swap back to see bank 0 untouched.
        drive(0, 0, 1, 3, 12'hF76, 0, 0);
        drive(0, 0, 0, 0, '0, 1, 0);
        idle(2);
        drive(0, 0, 0, 0, '0, 0, 1);
        drive(1, 3, 0, 0, '0, 0, 0);
        idle(3);
        drive(0, 0, 0, 0, '0, 1, 1);
        drive(1, 3, 0, 0, '0, 0, 0);
        idle(3);

        // Back-to-back stream over every index.
        for (int i = 0; i < (1 << IW); i++) drive(1, i, 0, 0, '0, 0, 0);
        idle(3);

        // Same-cycle request+frame_start flips; frame_start alone does not.
        drive(0, 0, 0, 0, '0, 1, 1);
        idle(1);
        drive(0, 0, 0, 0, '0, 0, 1);
        idle(1);
        drive(0, 0, 0, 0, '0, 1, 0);
        drive(0, 0, 0, 0, '0, 1, 0);
        drive(0, 0, 0, 0, '0, 0, 1);
        idle(1);

        // Write during the swap cycle lands in the newly active bank.
        drive(0, 0, 1, 2, 12'h5A3, 1, 1);
        drive(1, 2, 0, 0, '0, 0, 0);
        idle(3);

`ifdef PALETTE_DIM_EN
        drive(0, 0, 1, 0, 12'hFFF, 0, 0);
        dim_level = 2'd2;
        drive(0, 0, 0, 0, '0, 1, 1);
        drive(1, 0, 0, 0, '0, 0, 0);
        dim_level = 2'd0;
        drive(1, 0, 0, 0, '0, 0, 0);
        idle(2);
        drive(0, 0, 0, 0, '0, 0, 1);
        drive(1, 0, 0, 0, '0, 0, 0);
        idle(3);
`endif

        // Reset while pixels and a pending swap are in flight.
        drive(0, 0, 0, 0, '0, 1, 0);
        drive(1, 7, 0, 0, '0, 0, 0);
        drive(1, 8, 0, 0, '0, 0, 0);
        pix_valid_in = 1'b0;
        Reset_n = 1'b0;
        @(posedge Clk);
        #1;
        @(posedge Clk);
        #1 Reset_n = 1'b1;
        idle(2);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
`ifdef PALETTE_DIM_EN
            if ($urandom_range(0, 9) == 0) dim_level = 2'($urandom_range(0, 3));
`endif
            drive($urandom_range(0, 3) != 0, $urandom_range(0, (1 << IW) - 1),
                  $urandom_range(0, 2) == 0, $urandom_range(0, (1 << IW) - 1),
                  (3*CW)'($urandom), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 19) == 0);
        end
        idle(4);
        check("drain_queue_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
